// File: rtl/eth_pkg.sv
// Purpose : shared types and constants for the receive frame filter.
// Latency : n/a (types, constants and a combinational byte selector only).
// Backpr. : n/a.
package eth_pkg;

    // Write-side frame FSM.
    typedef enum logic [2:0] {
        WR_SYNC,
        WR_IDLE,
        WR_HDR,
        WR_BODY,
        WR_DROP
    } wr_state_t;

    localparam logic [47:0] ETH_ADDR_BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_HDR_ADDR_LEN = 6;

    // One buffer entry: frame byte plus its end-of-frame marker.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

    // Byte idx of a MAC address in wire order (byte 0 sits in bits [47:40]).
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    return addr[47:40];
            3'd1:    return addr[39:32];
            3'd2:    return addr[31:24];
            3'd3:    return addr[23:16];
            3'd4:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/eth_rx_frame_ram.sv
// Purpose : simple dual-port frame store, DEPTH x 9, one write port, one registered read port.
// Latency : read data valid the cycle after rd_en; rd_data holds while rd_en is low.
// Backpr. : none; the caller throttles rd_en.
// Ports   : wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered result.
module eth_rx_frame_ram
    import eth_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  buf_entry_t        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output buf_entry_t        rd_data
);

    buf_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Purpose : store-and-forward receive buffer; commits clean frames passing the DA filter, rewinds the rest.
// Latency : frame committed on its tlast beat in cycle T shows m_axis_tvalid in cycle T+2 (idle output).
// Backpr. : input never stalls (full drops the frame); output honours m_axis_tready, data held while stalled.
// Ports   : s_axis_* MAC byte stream in; m_axis_* committed frames out; cfg_mac_addr/cfg_promisc filter
//           setup; stat_* one-cycle pulses per frame outcome.
// Config  : ETH_RX_MAC_FILTER_EN compiles in the destination-address filter; without it every clean,
//           non-runt frame is committed and the cfg_* inputs are ignored.
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic [47:0] cfg_mac_addr,
    input  logic        cfg_promisc,
    output logic        stat_frame_good,
    output logic        stat_drop_bad,
    output logic        stat_drop_overflow,
    output logic        stat_drop_filter
);

    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE  = 1;

    wr_state_t       state, state_nxt;
    logic [ADDR_W:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0] wr_commit, wr_commit_nxt;
    logic [ADDR_W:0] rd_ptr;
    logic [2:0]      hdr_idx, hdr_idx_nxt;
    logic            wr_en, full, filter_ok;
    logic            good_nxt, bad_nxt, ovf_nxt, filt_nxt;
    logic            rd_en, rd_vld, out_take, empty;
    buf_entry_t      wr_entry, rd_entry;

    assign full     = (wr_ptr - rd_ptr) == FULL_LVL;
    assign wr_entry = '{last: s_axis_tlast, data: s_axis_tdata};

    // ---------------- write side ----------------
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        hdr_idx_nxt   = hdr_idx;
        wr_en         = 1'b0;
        good_nxt      = 1'b0;
        bad_nxt       = 1'b0;
        ovf_nxt       = 1'b0;
        filt_nxt      = 1'b0;
        if (s_axis_tvalid) begin
            case (state)
                WR_SYNC: begin
                    if (s_axis_tlast) state_nxt = WR_IDLE;
                end
                WR_DROP: begin
                    // Only an overflow leads here, so the cause is implied by the state.
                    if (s_axis_tlast) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = WR_IDLE;
                    end
                end
                WR_IDLE, WR_HDR, WR_BODY: begin
                    if (full) begin
                        wr_ptr_nxt = wr_commit;
                        if (s_axis_tlast) begin
                            ovf_nxt   = 1'b1;
                            state_nxt = WR_IDLE;
                        end else begin
                            state_nxt = WR_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        if (s_axis_tlast) begin
                            state_nxt = WR_IDLE;
                            if (s_axis_tuser || state != WR_BODY) begin
                                wr_ptr_nxt = wr_commit;
                                bad_nxt    = 1'b1;
                            end else if (!filter_ok) begin
                                wr_ptr_nxt = wr_commit;
                                filt_nxt   = 1'b1;
                            end else begin
                                wr_commit_nxt = wr_ptr + PTR_ONE;
                                good_nxt      = 1'b1;
                            end
                        end else if (state == WR_IDLE) begin
                            hdr_idx_nxt = 3'd1;
                            state_nxt   = WR_HDR;
                        end else if (state == WR_HDR) begin
                            hdr_idx_nxt = hdr_idx + 3'd1;
                            if (hdr_idx == 3'(ETH_HDR_ADDR_LEN - 1)) state_nxt = WR_BODY;
                        end
                    end
                end
                default: state_nxt = WR_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= WR_SYNC;
            wr_ptr             <= '0;
            wr_commit          <= '0;
            hdr_idx            <= '0;
            stat_frame_good    <= 1'b0;
            stat_drop_bad      <= 1'b0;
            stat_drop_overflow <= 1'b0;
            stat_drop_filter   <= 1'b0;
        end else begin
            state              <= state_nxt;
            wr_ptr             <= wr_ptr_nxt;
            wr_commit          <= wr_commit_nxt;
            hdr_idx            <= hdr_idx_nxt;
            stat_frame_good    <= good_nxt;
            stat_drop_bad      <= bad_nxt;
            stat_drop_overflow <= ovf_nxt;
            stat_drop_filter   <= filt_nxt;
        end
    end

`ifdef ETH_RX_MAC_FILTER_EN
    // Running per-byte comparison of the six destination bytes; byte 0 restarts the match.
    logic       hdr_beat, sta_eq, bc_eq;
    logic       match_sta, match_bc, promisc_q;
    logic [2:0] cmp_idx;

    always_comb begin
        hdr_beat = s_axis_tvalid && !full && (state == WR_IDLE || state == WR_HDR);
        cmp_idx  = (state == WR_IDLE) ? 3'd0 : hdr_idx;
        sta_eq   = s_axis_tdata == addr_byte(cfg_mac_addr, cmp_idx);
        bc_eq    = s_axis_tdata == addr_byte(ETH_ADDR_BCAST, cmp_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_sta <= 1'b0;
            match_bc  <= 1'b0;
            promisc_q <= 1'b0;
        end else if (hdr_beat) begin
            match_sta <= sta_eq && (state == WR_IDLE || match_sta);
            match_bc  <= bc_eq && (state == WR_IDLE || match_bc);
            promisc_q <= cfg_promisc;
        end
    end

    assign filter_ok = match_sta | match_bc | promisc_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_mac_addr, cfg_promisc};
    assign filter_ok  = 1'b1;
`endif

    // ---------------- read side ----------------
    // Emptiness is judged against the commit value being written this cycle so the RAM read
    // overlaps the commit edge. The address read then is always older than the current write
    // address because committed frames are at least seven bytes long.
    assign empty    = rd_ptr == wr_commit_nxt;
    assign out_take = !m_axis_tvalid || m_axis_tready;
    assign rd_en    = !empty && (!rd_vld || out_take);

    eth_rx_frame_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            rd_vld        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_vld <= 1'b1;
            end else if (out_take) begin
                rd_vld <= 1'b0;
            end
            if (out_take) begin
                m_axis_tvalid <= rd_vld;
                if (rd_vld) begin
                    m_axis_tdata <= rd_entry.data;
                    m_axis_tlast <= rd_entry.last;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
module tb_eth_rx_frame_filter;

    localparam logic [47:0] STA   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] cfg_mac = STA;
    logic        cfg_prom = 1'b0;

    logic [7:0] a_sd = '0, b_sd = '0;
    logic       a_sv = 0, a_sl = 0, a_su = 0, b_sv = 0, b_sl = 0, b_su = 0;
    logic [7:0] a_md, b_md;
    logic       a_mv, a_ml, b_mv, b_ml;
    logic       a_rdy, a_rdy_fix = 1'b1, b_rdy = 1'b0, rand_en = 1'b0, rnd_bit = 1'b0;
    logic       a_good, a_bad, a_ovf, a_filt, b_good, b_bad, b_ovf, b_filt;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] a_exp, b_exp, a_prev;
    logic       a_hold_chk = 1'b0;

    int n_cmp = 0, n_fail = 0, cyc = 0, last_tlast_cyc = 0;
    int ag = 0, ab = 0, ao = 0, af = 0, bg = 0, bb = 0, bo = 0, bf = 0;
    int exp_good = 0, exp_bad = 0, exp_filt = 0;

    assign a_rdy = rand_en ? rnd_bit : a_rdy_fix;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    eth_rx_frame_filter u_big (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_sd), .s_axis_tvalid(a_sv), .s_axis_tlast(a_sl), .s_axis_tuser(a_su),
        .m_axis_tdata(a_md), .m_axis_tvalid(a_mv), .m_axis_tready(a_rdy), .m_axis_tlast(a_ml),
        .cfg_mac_addr(cfg_mac), .cfg_promisc(cfg_prom),
        .stat_frame_good(a_good), .stat_drop_bad(a_bad),
        .stat_drop_overflow(a_ovf), .stat_drop_filter(a_filt)
    );

    eth_rx_frame_filter #(.DEPTH(64)) u_small (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv), .s_axis_tlast(b_sl), .s_axis_tuser(b_su),
        .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tready(b_rdy), .m_axis_tlast(b_ml),
        .cfg_mac_addr(cfg_mac), .cfg_promisc(cfg_prom),
        .stat_frame_good(b_good), .stat_drop_bad(b_bad),
        .stat_drop_overflow(b_ovf), .stat_drop_filter(b_filt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dst_byte(input logic [47:0] a, input int i);
        return a[8*(5-i) +: 8];
    endfunction

    // Scoreboard monitors: pop on every accepted output beat; stat pulses counted per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_good) ag++;
            if (a_bad)  ab++;
            if (a_ovf)  ao++;
            if (a_filt) af++;
            if (a_mv && a_hold_chk) chk("a_hold_stable", 32'({a_ml, a_md}), 32'(a_prev));
            if (a_mv && a_rdy) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL a_extra_beat: got %h, required no beat", {a_ml, a_md});
                end else begin
                    a_exp = qa.pop_front();
                    chk("a_beat", 32'({a_ml, a_md}), 32'(a_exp));
                end
            end
            a_hold_chk = a_mv && !a_rdy;
            a_prev     = {a_ml, a_md};
        end else begin
            a_hold_chk = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_good) bg++;
            if (b_bad)  bb++;
            if (b_ovf)  bo++;
            if (b_filt) bf++;
            if (b_mv && b_rdy) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b_extra_beat: got %h, required no beat", {b_ml, b_md});
                end else begin
                    b_exp = qb.pop_front();
                    chk("b_beat", 32'({b_ml, b_md}), 32'(b_exp));
                end
            end
        end
    end

    task automatic drive_beat(input bit on_b, input logic [7:0] d, input logic last, input logic user);
        if (on_b) begin
            b_sd = d; b_sv = 1'b1; b_sl = last; b_su = user;
        end else begin
            a_sd = d; a_sv = 1'b1; a_sl = last; a_su = user;
        end
        if (last) last_tlast_cyc = cyc;
        @(posedge clk); #1;
        a_sv = 1'b0; a_sl = 1'b0; a_su = 1'b0;
        b_sv = 1'b0; b_sl = 1'b0; b_su = 1'b0;
    endtask

    task automatic send_frame(input bit on_b, input logic [47:0] dst, input int len,
                              input logic [7:0] seed, input logic user, input bit emit);
        logic [7:0] d;
        logic       last;
        for (int i = 0; i < len; i++) begin
            d    = (i < 6) ? dst_byte(dst, i) : 8'(seed + 8'(i));
            last = (i == len - 1);
            if (emit) begin
                if (on_b) qb.push_back({last, d});
                else      qa.push_back({last, d});
            end
            drive_beat(on_b, d, last, last & user);
        end
    endtask

    task automatic wait_drain(input bit on_b, input string name);
        int n = 0;
        while (((on_b ? qb.size() : qa.size()) != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk(name, 32'(on_b ? qb.size() : qa.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_tvalid", 32'(a_mv), 0);
        chk("rst_a_tdata",  32'(a_md), 0);
        chk("rst_a_tlast",  32'(a_ml), 0);
        chk("rst_a_stats",  32'({a_good, a_bad, a_ovf, a_filt}), 0);
        chk("rst_b_tvalid", 32'(b_mv), 0);
        chk("rst_b_stats",  32'({b_good, b_bad, b_ovf, b_filt}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Leave SYNC on both instances with a lone tlast beat (silently discarded).
        drive_beat(0, 8'h55, 1'b1, 1'b0);
        drive_beat(1, 8'h55, 1'b1, 1'b0);

        // T1: good 64-byte frame, latency from tlast to tvalid is 2 cycles.
        send_frame(0, STA, 64, 8'h10, 1'b0, 1'b1);
        exp_good++;
        for (int k = 0; k < 20 && !a_mv; k++) @(negedge clk);
        chk("t1_latency", 32'(cyc - last_tlast_cyc), 2);
        wait_drain(0, "t1_drained");
        chk("t1_good_cnt", ag, exp_good);
        chk("t1_bad_cnt", ab, 0);

        // T2: tuser on tlast drops, next good frame passes.
        send_frame(0, STA, 64, 8'h40, 1'b1, 1'b0);
        exp_bad++;
        send_frame(0, STA, 64, 8'h80, 1'b0, 1'b1);
        exp_good++;
        wait_drain(0, "t2_drained");
        chk("t2_bad_cnt", ab, exp_bad);
        chk("t2_good_cnt", ag, exp_good);

        // T3: destination filter.
`ifdef ETH_RX_MAC_FILTER_EN
        send_frame(0, OTHER, 64, 8'h05, 1'b0, 1'b0);
        exp_filt++;
        cfg_prom = 1'b1;
        send_frame(0, OTHER, 64, 8'h05, 1'b0, 1'b1);
        exp_good++;
        cfg_prom = 1'b0;
        send_frame(0, BCAST, 64, 8'h07, 1'b0, 1'b1);
        exp_good++;
`else
        send_frame(0, OTHER, 64, 8'h05, 1'b0, 1'b1);
        exp_good++;
`endif
        wait_drain(0, "t3_drained");
        chk("t3_filt_cnt", af, exp_filt);
        chk("t3_good_cnt", ag, exp_good);

        // T4: frame held at the output, runt, partial frame, reset, tail, good frame.
        a_rdy_fix = 1'b0;
        send_frame(0, STA, 30, 8'hA0, 1'b0, 1'b0);
        exp_good++;
        send_frame(0, STA, 4, 8'h00, 1'b0, 1'b0);
        exp_bad++;
        for (int i = 0; i < 20; i++)
            drive_beat(0, (i < 6) ? dst_byte(STA, i) : 8'(i), 1'b0, 1'b0);
        chk("t4_runt_bad_cnt", ab, exp_bad);
        chk("t4_held_tvalid", 32'(a_mv), 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_tvalid", 32'(a_mv), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_rdy_fix = 1'b1;
        @(posedge clk); #1;
        for (int i = 20; i < 40; i++) drive_beat(0, 8'(i), i == 39, 1'b0);
        send_frame(0, STA, 64, 8'hC0, 1'b0, 1'b1);
        exp_good++;
        wait_drain(0, "t4_drained");
        chk("t4_good_cnt", ag, exp_good);
        chk("t4_bad_cnt", ab, exp_bad);

        // T5: DEPTH=64 instance, tready low, second 40-byte frame overflows.
        drive_beat(1, 8'h55, 1'b1, 1'b0);
        send_frame(1, STA, 40, 8'h20, 1'b0, 1'b1);
        send_frame(1, STA, 40, 8'h60, 1'b0, 1'b0);
        chk("t5_ovf_pulse_at_tlast", 32'(b_ovf), 1);
        chk("t5_b_tvalid_held", 32'(b_mv), 1);
        chk("t5_b_data_held", 32'({b_ml, b_md}), 32'h002);
        repeat (4) @(negedge clk);
        b_rdy = 1'b1;
        wait_drain(1, "t5_drained");
        chk("t5_ovf_cnt", bo, 1);
        chk("t5_good_cnt", bg, 1);
        chk("t5_bad_cnt", bb, 0);

        // T6: two buffered 60-byte frames stream without a tvalid gap, then random tready.
        a_rdy_fix = 1'b0;
        send_frame(0, STA, 60, 8'h30, 1'b0, 1'b1);
        send_frame(0, STA, 60, 8'h70, 1'b0, 1'b1);
        exp_good += 2;
        repeat (3) @(posedge clk);
        #1;
        a_rdy_fix = 1'b1;
        gaps = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!a_mv) gaps++;
        end
        chk("t6_no_gap", gaps, 0);
        wait_drain(0, "t6_gap_drained");
        rand_en = 1'b1;
        send_frame(0, STA, 60, 8'h11, 1'b0, 1'b1);
        send_frame(0, STA, 60, 8'h22, 1'b0, 1'b1);
        send_frame(0, STA, 60, 8'h33, 1'b0, 1'b1);
        exp_good += 3;
        wait_drain(0, "t6_rand_drained");
        rand_en = 1'b0;

        chk("final_a_good", ag, exp_good);
        chk("final_a_bad", ab, exp_bad);
        chk("final_a_ovf", ao, 0);
        chk("final_a_filt", af, exp_filt);
        chk("final_b_filt", bf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
